toggle_pulse_gen: RTL and testbench
===================================

Name: toggle_pulse_gen

Overview:
Upstream stage for the T flip-flop. Generates single-cycle toggle-enable pulses on t at a programmable period, in a finite or continuous burst, under a start/stop/busy/done handshake. t drives the flip-flop's toggle input directly. The flip-flop therefore toggles once per period, burst times, giving a programmable-rate square wave.

Parameters:
PER_W, 8, width of period input and internal phase counter
BST_W, 8, width of burst input and pulse counter

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  asynchronous, active-low reset; 0 clears all state immediately
start  input  1  request a burst; sampled only in IDLE
stop  input  1  abort an active burst
period  input  PER_W  cycles between t pulses; latched on accepted start
burst  input  BST_W  number of t pulses; 0 = continuous; latched on accepted start
t  output  1  toggle enable to flip-flop; single-cycle pulses
busy  output  1  high while in RUN
done  output  1  one-cycle pulse after the final pulse of a finite burst
pulse_cnt  output  BST_W  pulses emitted in current/last burst

Behaviour:
- Reset (rst=0, async): state=IDLE; t=0, busy=0, done=0, pulse_cnt=0; phase counter and latched period/burst = 0. Effective mid-burst, and is not synchronised to clk. On release, IDLE on the first edge.
- All outputs are registered. No combinational path from input to output.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start=1 and stop=0 at edge k: latch period (0 is treated as 1) and burst; clear phase and pulse_cnt; go to RUN. busy=1 from edge k.
  - start=1 and stop=1 together: stop wins; stay IDLE.
  - start=0: hold.
- RUN:
  - Phase counter increments each cycle.
  - When phase reaches P-1 (P = latched period): t=1 for exactly one cycle, phase returns to 0, pulse_cnt increments.
  - Timing: first t is high in the cycle after edge k+P. Subsequent pulses are spaced exactly P cycles.
  - P=1: t is high every RUN cycle.
  - start in RUN is ignored; period/burst changes are ignored until the next accepted start.
- Finite burst (B>0): the edge that emits pulse B moves to DONE. t is high that cycle, busy still 1.
- DONE (one cycle): done=1, busy=0, t=0; then IDLE unconditionally. start during DONE is ignored.
- Continuous (B=0): stays in RUN until stop. pulse_cnt wraps modulo 2^BST_W.
- stop=1 sampled in RUN:
  - Next state is IDLE, with busy=0 and t=0 from that edge.
  - No t pulse is emitted on the stop edge, even if phase hits P-1.
  - done is not asserted.
  - pulse_cnt holds its value.
- Steady state: pulse_cnt holds its value in IDLE until the next accepted start.
- Widths: phase is PER_W bits, pulse_cnt is BST_W bits, no overflow in phase since phase < P ≤ 2^PER_W-1.

Test Plan:
- rst=0 asserted between edges (mid-cycle) during RUN with t high -> t, busy, done, pulse_cnt read 0 immediately, before the next edge; IDLE after release.
- period=4, burst=3, start pulse at edge 0 -> busy=1 from edge 0; t high in the cycles after edges 4, 8, 12; done high the cycle after edge 13; busy=0 from edge 13; pulse_cnt=3.
- period=0, burst=5 -> treated as period 1; t high the 5 consecutive cycles after edges 1..5; done the cycle after edge 6; pulse_cnt=5.
- period=3, burst=0, stop at edge 10 -> t after edges 3, 6, 9; no t after edge 10; busy=0 from edge 10; done never asserted; pulse_cnt=3.
- start and stop high together in IDLE -> stays IDLE, busy=0. start re-pulsed during RUN with new period=2 -> ignored; spacing stays at the original 4.
- period=1, burst=0 with BST_W=8 run 260 cycles -> pulse_cnt wraps 255->0 and reads 4 after 260 pulses; t continuous.

Source files
------------

// File: rtl/toggle_pulse_gen.sv
// Programmable-rate toggle-enable pulse generator feeding a T flip-flop.
// Emits single-cycle t pulses every `period` cycles for `burst` pulses (0 = continuous).
module toggle_pulse_gen #(
  parameter int unsigned PER_W = 8,
  parameter int unsigned BST_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic [PER_W-1:0] period,
  input  logic [BST_W-1:0] burst,
  output logic             t,
  output logic             busy,
  output logic             done,
  output logic [BST_W-1:0] pulse_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [PER_W-1:0] phase;
  logic [PER_W-1:0] per_q;
  logic [BST_W-1:0] bst_q;
  logic [BST_W-1:0] cnt_inc;
  logic             accept;
  logic             hit;
  logic             last;
  logic             t_nxt;
  logic             busy_nxt;
  logic             done_nxt;

  assign cnt_inc = pulse_cnt + BST_W'(1);
  assign accept  = (state == IDLE) && start && !stop;
  // stop takes priority over a phase match, so no pulse is emitted on the stop edge
  assign hit     = (state == RUN) && !stop && (phase == per_q - PER_W'(1));
  assign last    = hit && (bst_q != '0) && (cnt_inc == bst_q);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (accept) state_nxt = RUN;
      RUN: begin
        if (stop)      state_nxt = IDLE;
        else if (last) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output values for the coming cycle; registered below so no input reaches an output combinationally.
  always_comb begin
    t_nxt    = hit;
    busy_nxt = (state_nxt == RUN) || last;
    done_nxt = (state == DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      t    <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      t    <= t_nxt;
      busy <= busy_nxt;
      done <= done_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase     <= '0;
      per_q     <= '0;
      bst_q     <= '0;
      pulse_cnt <= '0;
    end else if (accept) begin
      per_q     <= (period == '0) ? PER_W'(1) : period;
      bst_q     <= burst;
      phase     <= '0;
      pulse_cnt <= '0;
    end else if ((state == RUN) && !stop) begin
      if (hit) begin
        phase     <= '0;
        pulse_cnt <= cnt_inc;
      end else begin
        phase <= phase + PER_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_toggle_pulse_gen.sv
// Self-checking bench for toggle_pulse_gen: directed and random bursts against an
// arithmetic model of pulse timing, burst completion, stop and counter wrap.
module tb_toggle_pulse_gen;

  logic       clk;
  logic       rst;
  logic       start;
  logic       stop;
  logic [7:0] period;
  logic [7:0] burst;
  logic       t;
  logic       busy;
  logic       done;
  logic [7:0] pulse_cnt;

  int n_tests;
  int n_fail;

  toggle_pulse_gen #(.PER_W(8), .BST_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .stop      (stop),
    .period    (period),
    .burst     (burst),
    .t         (t),
    .busy      (busy),
    .done      (done),
    .pulse_cnt (pulse_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edge 0 is the edge that accepts start; outputs are checked at the negedge after each edge.
  // s > 0 is the edge at which stop is sampled (0 = no stop).
  task automatic run_burst(input string name, input int per_in, input int bst, input int s,
                           input bit repulse);
    int  p;
    int  end_e;
    bit  stopped;
    int  eff;
    int  c;
    bit  exp_t;
    bit  exp_busy;
    bit  exp_done;
    int  exp_cnt;
    p       = (per_in == 0) ? 1 : per_in;
    stopped = (s > 0) && ((bst == 0) || (s <= bst * p));
    end_e   = stopped ? s : bst * p + 1;
    @(negedge clk);
    start  = 1'b1;
    stop   = 1'b0;
    period = 8'(per_in);
    burst  = 8'(bst);
    for (int e = 0; e <= end_e + 3; e++) begin
      @(posedge clk);
      @(negedge clk);
      exp_t = (e > 0) && (e % p == 0) && ((bst == 0) || (e / p <= bst)) && !(stopped && e >= s);
      eff   = (stopped && e >= s) ? s - 1 : e;
      c     = eff / p;
      if (bst > 0 && c > bst) c = bst;
      exp_cnt  = c % 256;
      exp_busy = stopped ? (e < s) : ((bst > 0) ? (e <= bst * p) : 1'b1);
      exp_done = !stopped && (bst > 0) && (e == bst * p + 1);
      n_tests += 4;
      if (t !== exp_t) begin
        n_fail++;
        $display("FAIL %s t edge=%0d got=%b exp=%b", name, e, t, exp_t);
      end
      if (busy !== exp_busy) begin
        n_fail++;
        $display("FAIL %s busy edge=%0d got=%b exp=%b", name, e, busy, exp_busy);
      end
      if (done !== exp_done) begin
        n_fail++;
        $display("FAIL %s done edge=%0d got=%b exp=%b", name, e, done, exp_done);
      end
      if (pulse_cnt !== 8'(exp_cnt)) begin
        n_fail++;
        $display("FAIL %s pulse_cnt edge=%0d got=%0d exp=%0d", name, e, pulse_cnt, exp_cnt);
      end
      // Re-pulsed start and new period/burst values must be ignored while a burst is active.
      start  = repulse && (e + 1 <= end_e) && ($urandom % 3 == 0);
      period = repulse ? 8'd2 : 8'($urandom);
      burst  = 8'($urandom);
      stop   = (s > 0) && (e + 1 == s);
    end
    start = 1'b0;
    stop  = 1'b0;
  endtask

  task automatic test_reset();
    bit seen;
    rst = 1'b0; start = 1'b0; stop = 1'b0; period = '0; burst = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_tests += 4;
    if (t !== 1'b0)       begin n_fail++; $display("FAIL reset_t got=%b exp=0", t); end
    if (busy !== 1'b0)    begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
    if (done !== 1'b0)    begin n_fail++; $display("FAIL reset_done got=%b exp=0", done); end
    if (pulse_cnt !== '0) begin n_fail++; $display("FAIL reset_cnt got=%0d exp=0", pulse_cnt); end
    rst = 1'b1;
    @(negedge clk);
    start = 1'b1; period = 8'd2; burst = 8'd0;
    @(negedge clk);
    start = 1'b0;
    seen  = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (t === 1'b1 && pulse_cnt !== '0) seen = 1'b1;
    end
    n_tests++;
    if (!seen) begin n_fail++; $display("FAIL reset_setup_t got=0 exp=1 within 10 cycles"); end
    #2 rst = 1'b0;
    #1;
    n_tests += 4;
    if (t !== 1'b0)       begin n_fail++; $display("FAIL async_reset_t got=%b exp=0", t); end
    if (busy !== 1'b0)    begin n_fail++; $display("FAIL async_reset_busy got=%b exp=0", busy); end
    if (done !== 1'b0)    begin n_fail++; $display("FAIL async_reset_done got=%b exp=0", done); end
    if (pulse_cnt !== '0) begin n_fail++; $display("FAIL async_reset_cnt got=%0d exp=0", pulse_cnt); end
    #1 rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      n_tests += 2;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL post_reset_busy got=%b exp=0", busy); end
      if (t !== 1'b0)    begin n_fail++; $display("FAIL post_reset_t got=%b exp=0", t); end
    end
  endtask

  task automatic test_finite();
    run_burst("finite_p4_b3", 4, 3, 0, 1'b0);
  endtask

  task automatic test_period_zero();
    run_burst("period0_b5", 0, 5, 0, 1'b0);
  endtask

  task automatic test_stop();
    run_burst("stop_p3_cont", 3, 0, 10, 1'b0);
  endtask

  task automatic test_start_stop_collide();
    @(negedge clk);
    start = 1'b1; stop = 1'b1; period = 8'd3; burst = 8'd2;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    repeat (4) begin
      @(negedge clk);
      n_tests += 3;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL collide_busy got=%b exp=0", busy); end
      if (t !== 1'b0)    begin n_fail++; $display("FAIL collide_t got=%b exp=0", t); end
      if (done !== 1'b0) begin n_fail++; $display("FAIL collide_done got=%b exp=0", done); end
    end
  endtask

  task automatic test_ignore_start();
    run_burst("restart_ignored_p4", 4, 3, 0, 1'b1);
  endtask

  task automatic test_wrap();
    run_burst("wrap_p1_cont", 1, 0, 261, 1'b0);
  endtask

  task automatic test_random();
    int p;
    int b;
    int s;
    for (int i = 0; i < 10; i++) begin
      p = $urandom_range(6, 0);
      b = $urandom_range(5, 0);
      if (b == 0) s = $urandom_range(25, 1);
      else if ($urandom % 3 == 0) s = $urandom_range(b * ((p == 0) ? 1 : p), 1);
      else s = 0;
      run_burst("random", p, b, s, ($urandom % 2) == 1);
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    test_reset();
    test_finite();
    test_period_zero();
    test_stop();
    test_start_stop_collide();
    test_ignore_start();
    test_wrap();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
